// File: rtl/retire_free_list_pkg.sv
// Shared constants and types for the retire-side physical-register free list.
// Retire word layout is shared with the ROB: {valid, rd_old, data, rd}.
package retire_free_list_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int TAG_W     = $clog2(NUM_PREGS);
  localparam int PTR_W     = TAG_W + 1;
  localparam int CNT_W     = 7;

  localparam int RETIRE_WIDTH   = 45;
  localparam int RETIRE_VALID   = 44;
  localparam int RETIRE_OLD_HI  = 43;
  localparam int RETIRE_OLD_LO  = 38;
  localparam int RETIRE_DATA_HI = 37;
  localparam int RETIRE_DATA_LO = 6;
  localparam int RETIRE_RD_HI   = 5;
  localparam int RETIRE_RD_LO   = 0;

  typedef struct packed {
    logic             en;
    logic [TAG_W-1:0] tag;
  } free_req_t;

  // Initial FIFO contents: the unmapped tags NUM_AREGS.. fill the first slots.
  function automatic logic [TAG_W-1:0] reset_entry(input int idx);
    logic [TAG_W-1:0] v;
    if (idx < NUM_PREGS - NUM_AREGS) begin
      v = TAG_W'(NUM_AREGS + idx);
    end else begin
      v = {TAG_W{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/retire_decode.sv
// Splits two retire words into free-enable/tag pairs, filtering p0 and
// (with FREELIST_DBLFREE_CHECK_EN) tags already present in the free list.
module retire_decode
  import retire_free_list_pkg::*;
(
`ifdef FREELIST_DBLFREE_CHECK_EN
  input  logic [NUM_PREGS-1:0]    i_in_list,
`endif
  input  logic [RETIRE_WIDTH-1:0] i_retire0,
  input  logic [RETIRE_WIDTH-1:0] i_retire1,
  output free_req_t               o_free0,
  output free_req_t               o_free1,
  output logic                    o_dup_err
);

  logic             w_raw0_en;
  logic             w_raw1_en;
  logic [TAG_W-1:0] w_tag0;
  logic [TAG_W-1:0] w_tag1;
  logic             w_dup0;
  logic             w_dup1;
  logic             w_unused_fields;

  assign w_tag0    = i_retire0[RETIRE_OLD_HI:RETIRE_OLD_LO];
  assign w_tag1    = i_retire1[RETIRE_OLD_HI:RETIRE_OLD_LO];
  assign w_raw0_en = i_retire0[RETIRE_VALID] && (w_tag0 != {TAG_W{1'b0}});
  assign w_raw1_en = i_retire1[RETIRE_VALID] && (w_tag1 != {TAG_W{1'b0}});

  assign w_unused_fields = ^{i_retire0[RETIRE_DATA_HI:RETIRE_RD_LO],
                             i_retire1[RETIRE_DATA_HI:RETIRE_RD_LO]};

`ifdef FREELIST_DBLFREE_CHECK_EN
  // A kept retire0 tag counts as already listed for retire1.
  assign w_dup0 = w_raw0_en && i_in_list[w_tag0];
  assign w_dup1 = w_raw1_en && (i_in_list[w_tag1] ||
                                (w_raw0_en && !w_dup0 && (w_tag1 == w_tag0)));
`else
  assign w_dup0 = 1'b0;
  assign w_dup1 = 1'b0;
`endif

  assign o_free0.en  = w_raw0_en && !w_dup0;
  assign o_free0.tag = w_tag0;
  assign o_free1.en  = w_raw1_en && !w_dup1;
  assign o_free1.tag = w_tag1;
  assign o_dup_err   = w_dup0 || w_dup1;

endmodule

// File: rtl/retire_free_list.sv
// Circular free list of physical tags: up to two frees from retire, one alloc
// to rename per cycle. Optional duplicate-free check: FREELIST_DBLFREE_CHECK_EN.
module retire_free_list
  import retire_free_list_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_alloc_req,
  output logic [TAG_W-1:0]        o_alloc_tag,
  output logic                    o_alloc_valid,
  input  logic [RETIRE_WIDTH-1:0] i_retire0,
  input  logic [RETIRE_WIDTH-1:0] i_retire1,
  output logic [CNT_W-1:0]        o_free_count,
  output logic                    o_err
);

  logic [TAG_W-1:0] r_mem [NUM_PREGS];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  free_req_t        w_free0;
  free_req_t        w_free1;
  logic             w_dup_err;
  logic             w_alloc;
  logic [CNT_W-1:0] w_room;
  logic [CNT_W-1:0] w_need1;
  logic             w_keep0;
  logic             w_keep1;
  logic             w_ovf_err;
  logic [CNT_W-1:0] w_n_free;
  logic             w_wr0_en;
  logic             w_wr1_en;
  logic [TAG_W-1:0] w_wr0_tag;
  logic [TAG_W-1:0] w_wr0_idx;
  logic [TAG_W-1:0] w_wr1_idx;

`ifdef FREELIST_DBLFREE_CHECK_EN
  logic [NUM_PREGS-1:0] r_in_list;
  logic [NUM_PREGS-1:0] w_in_list_next;
`endif

  retire_decode u_decode (
`ifdef FREELIST_DBLFREE_CHECK_EN
    .i_in_list (r_in_list),
`endif
    .i_retire0 (i_retire0),
    .i_retire1 (i_retire1),
    .o_free0   (w_free0),
    .o_free1   (w_free1),
    .o_dup_err (w_dup_err)
  );

  assign o_alloc_valid = (r_count != {CNT_W{1'b0}});
  assign o_alloc_tag   = r_mem[r_head[TAG_W-1:0]];
  assign o_free_count  = r_count;
  assign o_err         = r_err;

  assign w_alloc = i_alloc_req && o_alloc_valid;

  // Room is judged against the pre-alloc count; retire0 claims space first.
  assign w_room    = CNT_W'(NUM_PREGS) - r_count;
  assign w_need1   = w_keep0 ? CNT_W'(2) : CNT_W'(1);
  assign w_keep0   = w_free0.en && (w_room != {CNT_W{1'b0}});
  assign w_keep1   = w_free1.en && (w_room >= w_need1);
  assign w_ovf_err = (w_free0.en && !w_keep0) || (w_free1.en && !w_keep1);
  assign w_n_free  = CNT_W'(w_keep0) + CNT_W'(w_keep1);

  assign w_wr0_en  = w_keep0 || w_keep1;
  assign w_wr1_en  = w_keep0 && w_keep1;
  assign w_wr0_tag = w_keep0 ? w_free0.tag : w_free1.tag;
  assign w_wr0_idx = r_tail[TAG_W-1:0];
  assign w_wr1_idx = r_tail[TAG_W-1:0] + TAG_W'(1);

`ifdef FREELIST_DBLFREE_CHECK_EN
  // Membership: clear the popped tag, then mark the newly written ones.
  always_comb begin
    w_in_list_next = r_in_list;
    if (w_alloc) begin
      w_in_list_next[o_alloc_tag] = 1'b0;
    end else begin
      w_in_list_next = w_in_list_next;
    end
    if (w_wr0_en) begin
      w_in_list_next[w_wr0_tag] = 1'b1;
    end else begin
      w_in_list_next = w_in_list_next;
    end
    if (w_wr1_en) begin
      w_in_list_next[w_free1.tag] = 1'b1;
    end else begin
      w_in_list_next = w_in_list_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_list <= {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
    end else begin
      r_in_list <= w_in_list_next;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_mem[i] <= reset_entry(i);
      end
    end else begin
      if (w_wr0_en) begin
        r_mem[w_wr0_idx] <= w_wr0_tag;
      end
      if (w_wr1_en) begin
        r_mem[w_wr1_idx] <= w_free1.tag;
      end
    end
  end

  // Pointers carry a wrap bit above the index; count is kept separately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= PTR_W'(NUM_PREGS - NUM_AREGS);
      r_count <= CNT_W'(NUM_PREGS - NUM_AREGS);
      r_err   <= 1'b0;
    end else begin
      r_head  <= r_head + PTR_W'(w_alloc);
      r_tail  <= r_tail + PTR_W'(w_n_free);
      r_count <= r_count + w_n_free - CNT_W'(w_alloc);
      r_err   <= r_err || w_dup_err || w_ovf_err;
    end
  end

endmodule

// File: tb/tb_retire_free_list.sv
// Scoreboard bench for retire_free_list: a queue model of the free list
// predicts every alloc tag, count and the sticky error flag.
module tb_retire_free_list;
  import retire_free_list_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    alloc_req;
  logic [5:0]              alloc_tag;
  logic                    alloc_valid;
  logic [RETIRE_WIDTH-1:0] retire0;
  logic [RETIRE_WIDTH-1:0] retire1;
  logic [6:0]              free_count;
  logic                    err;

  int         n_checks;
  int         n_errors;
  logic [5:0] exp_q[$];
  logic       exp_err;

  retire_free_list dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_alloc_req   (alloc_req),
    .o_alloc_tag   (alloc_tag),
    .o_alloc_valid (alloc_valid),
    .i_retire0     (retire0),
    .i_retire1     (retire1),
    .o_free_count  (free_count),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RETIRE_WIDTH-1:0] rw(input logic v, input logic [5:0] old);
    logic [31:0] d;
    logic [5:0]  rd;
    d  = $urandom;
    rd = 6'($urandom_range(63, 0));
    return {v, old, d, rd};
  endfunction

  function automatic bit in_q(input logic [5:0] t);
    foreach (exp_q[i]) if (exp_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q = {};
    for (int i = 32; i < 64; i++) exp_q.push_back(6'(i));
    exp_err = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the model; outputs are sampled #1 after the edge.
  task automatic step(input logic a, input logic v0, input logic [5:0] o0,
                      input logic v1, input logic [5:0] o1);
    int sz;
    bit k0, k1, aok;
    sz  = exp_q.size();
    aok = a && (sz > 0);
    k0  = v0 && (o0 != 6'd0);
    k1  = v1 && (o1 != 6'd0);
`ifdef FREELIST_DBLFREE_CHECK_EN
    if (k0 && in_q(o0)) begin k0 = 1'b0; exp_err = 1'b1; end
    if (k1 && (in_q(o1) || (k0 && o1 == o0))) begin k1 = 1'b0; exp_err = 1'b1; end
`endif
    if (k0 && sz + 1 > 64) begin k0 = 1'b0; exp_err = 1'b1; end
    if (k1 && sz + int'(k0) + 1 > 64) begin k1 = 1'b0; exp_err = 1'b1; end
    alloc_req = a;
    retire0   = rw(v0, o0);
    retire1   = rw(v1, o1);
    @(posedge clk);
    #1;
    if (aok) void'(exp_q.pop_front());
    if (k0) exp_q.push_back(o0);
    if (k1) exp_q.push_back(o1);
    alloc_req = 1'b0;
    retire0   = rw(1'b0, 6'd0);
    retire1   = rw(1'b0, 6'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (alloc_tag !== 6'd32 || alloc_valid !== 1'b1 || free_count !== 7'd32 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: got tag=%0d valid=%0b count=%0d err=%0b required tag=32 valid=1 count=32 err=0",
               alloc_tag, alloc_valid, free_count, err);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (alloc_tag !== exp_q[0] || alloc_tag !== 6'(32 + i)) begin
        n_errors++;
        $display("FAIL drain_tag[%0d]: got %0d required %0d", i, alloc_tag, exp_q[0]);
      end
      step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    end
    n_checks++;
    if (alloc_valid !== 1'b0 || free_count !== 7'd0) begin
      n_errors++;
      $display("FAIL drain_empty: got valid=%0b count=%0d required valid=0 count=0", alloc_valid, free_count);
    end
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_checks++;
    if (alloc_valid !== 1'b0 || free_count !== 7'(exp_q.size()) || err !== exp_err) begin
      n_errors++;
      $display("FAIL alloc_when_empty: got valid=%0b count=%0d err=%0b required valid=0 count=%0d err=%0b",
               alloc_valid, free_count, err, exp_q.size(), exp_err);
    end
  endtask

  task automatic test_dual_free();
    // Free 5 and 9 while empty, with a refused alloc in the same cycle.
    step(1'b1, 1'b1, 6'd5, 1'b1, 6'd9);
    n_checks++;
    if (alloc_valid !== 1'b1 || free_count !== 7'd2 || alloc_tag !== exp_q[0] || alloc_tag !== 6'd5) begin
      n_errors++;
      $display("FAIL dual_free: got valid=%0b count=%0d tag=%0d required valid=1 count=2 tag=%0d",
               alloc_valid, free_count, alloc_tag, exp_q[0]);
    end
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    n_checks++;
    if (alloc_tag !== exp_q[0] || alloc_tag !== 6'd9 || free_count !== 7'd1) begin
      n_errors++;
      $display("FAIL dual_second: got tag=%0d count=%0d required tag=%0d count=1", alloc_tag, free_count, exp_q[0]);
    end
  endtask

  task automatic test_filtered();
    step(1'b0, 1'b1, 6'd0, 1'b0, 6'd20);
    n_checks++;
    if (free_count !== 7'(exp_q.size()) || free_count !== 7'd1) begin
      n_errors++;
      $display("FAIL filtered_free: got count=%0d required %0d", free_count, exp_q.size());
    end
  endtask

  task automatic test_count_one();
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    step(1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
    n_checks++;
    if (alloc_tag !== 6'd40 || free_count !== 7'd1) begin
      n_errors++;
      $display("FAIL count_one_setup: got tag=%0d count=%0d required tag=40 count=1", alloc_tag, free_count);
    end
    step(1'b1, 1'b1, 6'd7, 1'b0, 6'd0);
    n_checks++;
    if (alloc_tag !== exp_q[0] || alloc_tag !== 6'd7 || free_count !== 7'd1 || alloc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL count_one: got tag=%0d count=%0d valid=%0b required tag=7 count=1 valid=1",
               alloc_tag, free_count, alloc_valid);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] prev;
    logic [5:0] h;
    int         bad;
    bad = 0;
    prev = 6'd0;
    step(1'b0, 1'b1, 6'd10, 1'b1, 6'd11);
    for (int i = 0; i < 200; i++) begin
      h = exp_q[0];
      if (alloc_tag !== h || free_count !== 7'(exp_q.size())) begin
        bad++;
        if (bad < 4)
          $display("FAIL wrap[%0d]: got tag=%0d count=%0d required tag=%0d count=%0d",
                   i, alloc_tag, free_count, h, exp_q.size());
      end
      step(1'b1, prev != 6'd0, prev, 1'b0, 6'd0);
      prev = h;
    end
    n_checks++;
    if (bad != 0) n_errors++;
    n_checks++;
    if (free_count !== 7'(exp_q.size()) || alloc_tag !== exp_q[0]) begin
      n_errors++;
      $display("FAIL wrap_end: got tag=%0d count=%0d required tag=%0d count=%0d",
               alloc_tag, free_count, exp_q[0], exp_q.size());
    end
  endtask

`ifndef FREELIST_DBLFREE_CHECK_EN
  task automatic test_overflow();
    int bad;
    int t;
    bad = 0;
    t = 0;
    while (exp_q.size() + 2 <= 63) begin
      step(1'b0, 1'b1, 6'(1 + (t % 63)), 1'b1, 6'(1 + ((t + 1) % 63)));
      t += 2;
    end
    if (exp_q.size() < 63) step(1'b0, 1'b1, 6'd3, 1'b0, 6'd0);
    n_checks++;
    if (free_count !== 7'd63 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_63: got count=%0d err=%0b required count=63 err=0", free_count, err);
    end
    step(1'b0, 1'b1, 6'd50, 1'b1, 6'd51);
    n_checks++;
    if (free_count !== 7'd64 || err !== 1'b1 || exp_q[63] !== 6'd50) begin
      n_errors++;
      $display("FAIL overflow: got count=%0d err=%0b required count=64 err=1", free_count, err);
    end
    for (int i = 0; i < 64; i++) begin
      if (alloc_tag !== exp_q[0]) begin
        bad++;
        if (bad < 4) $display("FAIL overflow_drain[%0d]: got %0d required %0d", i, alloc_tag, exp_q[0]);
      end
      step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    end
    n_checks++;
    if (bad != 0 || free_count !== 7'd0 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_drain: got count=%0d err=%0b required count=0 err=1", free_count, err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 6'd21, 1'b1, 6'd22);
    alloc_req = 1'b1;
    retire0   = rw(1'b1, 6'd23);
    retire1   = rw(1'b1, 6'd24);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (alloc_tag !== 6'd32 || alloc_valid !== 1'b1 || free_count !== 7'd32 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: got tag=%0d valid=%0b count=%0d err=%0b required tag=32 valid=1 count=32 err=0",
               alloc_tag, alloc_valid, free_count, err);
    end
    alloc_req = 1'b0;
    retire0   = rw(1'b0, 6'd0);
    retire1   = rw(1'b0, 6'd0);
    do_reset();
    n_checks++;
    if (free_count !== 7'd32 || alloc_tag !== exp_q[0]) begin
      n_errors++;
      $display("FAIL after_reset: got tag=%0d count=%0d required tag=32 count=32", alloc_tag, free_count);
    end
  endtask

  task automatic test_dup();
    step(1'b0, 1'b1, 6'd12, 1'b1, 6'd12);
    n_checks++;
    if (free_count !== 7'(exp_q.size()) || err !== exp_err) begin
      n_errors++;
      $display("FAIL dup_same_cycle: got count=%0d err=%0b required count=%0d err=%0b",
               free_count, err, exp_q.size(), exp_err);
    end
    do_reset();
    step(1'b0, 1'b1, 6'd33, 1'b0, 6'd0);
    n_checks++;
    if (free_count !== 7'(exp_q.size()) || err !== exp_err) begin
      n_errors++;
      $display("FAIL dup_listed: got count=%0d err=%0b required count=%0d err=%0b",
               free_count, err, exp_q.size(), exp_err);
    end
    for (int i = 0; i < 34; i++) begin
      n_checks++;
      if (alloc_valid !== (exp_q.size() != 0) || (exp_q.size() != 0 && alloc_tag !== exp_q[0])) begin
        n_errors++;
        $display("FAIL dup_drain[%0d]: got tag=%0d valid=%0b required valid=%0b", i, alloc_tag, alloc_valid,
                 exp_q.size() != 0);
      end
      step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    alloc_req = 1'b0;
    retire0   = '0;
    retire1   = '0;
    model_reset();
    test_reset();
    test_drain();
    test_dual_free();
    test_filtered();
    test_count_one();
    test_wrap();
`ifndef FREELIST_DBLFREE_CHECK_EN
    test_overflow();
`endif
    test_reset_mid();
    test_dup();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
